// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, reset PC and FSM state type for the fetch front end.
// No ports; imported by fetch_queue and fetch_unit.
package cpu_pkg;

  localparam int CPU_ADDR_W      = 10;
  localparam int CPU_INSTR_W     = 48;
  localparam int CPU_FETCH_DEPTH = 2;

  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {pc, instr} with synchronous flush.
// Ports: clk, reset, flush, push/din, pop, count, head (oldest entry).
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = CPU_FETCH_DEPTH,
  parameter int W     = CPU_ADDR_W + CPU_INSTR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: pointers gate what is visible
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/FSM, BRAM read issue, epoch-tagged in-flight read, prefetch queue.
// Ports: clk, reset, fetch_en, redirect_valid/pc, mem_addr/req/rdata,
// instr_valid/data/pc/ready; stall_cnt/fetched_cnt with FETCH_PERF_CNT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W,
  parameter int DEPTH = CPU_FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_req,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        fetched_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fly_pc;
  logic              epoch;
  logic              fly;
  logic              fly_epoch;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [CW:0]       occ;
  logic              flush;
  logic              pop;
  logic              push;
  logic              issue;

  assign flush       = redirect_valid && (state != IDLE);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !flush;
  // a read issued before a redirect carries the old epoch and is dropped
  assign push        = fly && (fly_epoch == epoch);

  // the slot freed by this cycle's pop already counts as free,
  // which keeps a 1/cycle stream going with a two-entry queue
  assign occ = {1'b0, count} + {{CW{1'b0}}, fly}
             - {{CW{1'b0}}, pop};
  assign issue = (state == RUN) && fetch_en && (occ < LIMIT);

  assign mem_req    = issue;
  assign mem_addr   = pc;
  assign instr_pc   = instr_valid ? head[EW-1:INSTR_W] : '0;
  assign instr_data = instr_valid ? head[INSTR_W-1:0] : '0;

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({fly_pc, mem_rdata}),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      fly_pc    <= '0;
      epoch     <= 1'b0;
      fly       <= 1'b0;
      fly_epoch <= 1'b0;
    end else begin
      fly       <= issue;
      fly_pc    <= pc;
      fly_epoch <= epoch;
      unique case (state)
        IDLE: state <= RUN;
        RUN, FLUSH: begin
          if (redirect_valid) begin
            state <= FLUSH;
            pc    <= redirect_pc;
            epoch <= ~epoch;
          end else begin
            state <= RUN;
            if (issue) pc <= pc + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= '0;
      fetched_cnt <= '0;
    end else begin
      if (instr_ready && !instr_valid && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (pop && fetched_cnt != 16'hFFFF)
        fetched_cnt <= fetched_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed corner sequences and random
// stimulus checked cycle by cycle against a queue-based fetch model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int AW = 10;
  localparam int IW = 48;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic [IW-1:0] mem_rdata;
  logic          instr_valid;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   fetched_cnt;
  int            m_stall;
  int            m_fetched;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .fetched_cnt    (fetched_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] rom(input int a);
    return IW'(48'h1000) + IW'(a);
  endfunction

  always @(posedge clk) mem_rdata <= rom(int'(mem_addr));

  // reference model: queue of pcs plus one pending read
  int m_q[$];
  int log_q[$];
  bit m_known = 0;
  bit m_fresh, m_flush, m_fly, m_fly_live;
  int m_pc, m_fly_pc;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input int exp);
    chk(name, (idx < log_q.size()) ? log_q[idx] : -1, exp);
  endtask

  task automatic cycle(input bit rst, input bit en, input bit rv,
                       input int rpc, input bit rdy);
    bit e_valid, e_req, pop, redir;
    int e_pc;
    @(negedge clk);
    reset = rst;
    fetch_en = en;
    redirect_valid = rv;
    redirect_pc = AW'(rpc);
    instr_ready = rdy;
    #1;
    redir = rv && !m_fresh;
    e_valid = m_q.size() > 0;
    e_pc = e_valid ? m_q[0] : 0;
    pop = e_valid && rdy && !redir;
    e_req = !m_fresh && !m_flush && en
         && (m_q.size() - int'(pop) + int'(m_fly)) < DEPTH;
    if (m_known) begin
      chk("mem_req", mem_req, e_req);
      chk("mem_addr", mem_addr, m_pc);
      chk("instr_valid", instr_valid, e_valid);
      chk("instr_pc", instr_pc, e_pc);
      chk("instr_data", instr_data, e_valid ? rom(e_pc) : '0);
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("fetched_cnt", fetched_cnt, m_fetched);
`endif
      if (pop && !rst) log_q.push_back(int'(instr_pc));
    end
`ifdef FETCH_PERF_CNT_EN
    if (rst) begin
      m_stall = 0;
      m_fetched = 0;
    end else begin
      if (rdy && !e_valid && m_stall < 65535) m_stall++;
      if (pop && m_fetched < 65535) m_fetched++;
    end
`endif
    if (rst) begin
      m_known = 1;
      m_q.delete();
      m_fresh = 1;
      m_flush = 0;
      m_fly = 0;
      m_fly_live = 0;
      m_pc = 0;
    end else if (redir) begin
      m_q.delete();
      m_flush = 1;
      m_pc = rpc;
      m_fly = e_req;
      m_fly_live = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_fly && m_fly_live) m_q.push_back(m_fly_pc);
      m_fly = e_req;
      m_fly_pc = m_pc;
      m_fly_live = 1;
      if (e_req) m_pc = (m_pc + 1) % 1024;
      m_fresh = 0;
      m_flush = 0;
    end
  endtask

  task automatic run(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, en, 0, 0, rdy);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit req;
    int addr;
    bit valid;
    int pc;
  } vec_t;

  vec_t tbl[7];
  int   head_pc;

  initial begin
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0};
    tbl[2] = '{1, 1, 0, 0};
    tbl[3] = '{1, 2, 1, 0};
    tbl[4] = '{1, 3, 1, 1};
    tbl[5] = '{1, 4, 1, 2};
    tbl[6] = '{1, 5, 1, 3};

    // 1: cold start, streaming
    do_reset();
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", mem_req, 0);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, 0, 0, 1);
      chk($sformatf("t1_req%0d", i), mem_req, tbl[i].req);
      chk($sformatf("t1_addr%0d", i), mem_addr, tbl[i].addr);
      chk($sformatf("t1_valid%0d", i), instr_valid, tbl[i].valid);
      if (tbl[i].valid)
        chk($sformatf("t1_pc%0d", i), instr_pc, tbl[i].pc);
    end

    // 2: backpressure fills queue, then drains in order
    do_reset();
    log_q.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (i >= 3) chk("t2_head", instr_pc, 0);
    end
    chk("t2_req_off", mem_req, 0);
    run(8, 1, 1);
    for (int i = 0; i < 6; i++) chk_log("t2_order", i, i);

    // 3: redirect with a read in flight
    run(4, 1, 1);
    log_q.delete();
    cycle(0, 1, 1, 'h200, 1);
    cycle(0, 1, 0, 0, 1);
    chk("t3_flush_req", mem_req, 0);
    chk("t3_flush_addr", mem_addr, 'h200);
    cycle(0, 1, 0, 0, 1);
    chk("t3_first_req", mem_req, 1);
    cycle(0, 1, 0, 0, 1);
    chk("t3_r3_valid", instr_valid, 0);
    cycle(0, 1, 0, 0, 1);
    chk("t3_r4_valid", instr_valid, 1);
    run(3, 1, 1);
    chk_log("t3_pc0", 0, 'h200);
    chk_log("t3_pc1", 1, 'h201);

    // 4: wrap at top of address space
    log_q.delete();
    cycle(0, 1, 1, 'h3FF, 1);
    run(8, 1, 1);
    chk_log("t4_pc0", 0, 'h3FF);
    chk_log("t4_pc1", 1, 'h000);
    chk_log("t4_pc2", 2, 'h001);

    // 5: back-to-back redirects, newest wins
    log_q.delete();
    cycle(0, 1, 1, 'h040, 1);
    cycle(0, 1, 1, 'h080, 1);
    run(8, 1, 1);
    chk_log("t5_pc0", 0, 'h080);
    chk_log("t5_pc1", 1, 'h081);

    // 6: reset mid-stream
    chk("t6_pre_valid", instr_valid, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    chk("t6_valid", instr_valid, 0);
    chk("t6_data", instr_data, 0);
    chk("t6_pc", instr_pc, 0);
    chk("t6_req", mem_req, 0);
    chk("t6_addr", mem_addr, 0);
    log_q.delete();
    run(6, 1, 1);
    chk_log("t6_restart", 0, 0);

    // fetch_en low holds pc and keeps draining
    run(3, 0, 1);
    chk("en_off_req", mem_req, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 1023)),
            $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
